// File: rtl/kbd_pkg.sv
// Shared keyboard constants: repeat FSM encoding and default timing for the 10 MHz clock.
package kbd_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StDelay,
      StRepeat
   } rpt_state_e;

   localparam int unsigned CLK_HZ            = 10_000_000;
   localparam int unsigned KBD_REPEAT_DELAY  = CLK_HZ / 2;   // 500 ms
   localparam int unsigned KBD_REPEAT_PERIOD = CLK_HZ / 10;  // 100 ms

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head, full, empty and count outputs.
module sync_fifo #(
   parameter int unsigned WIDTH = 7,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_wdata,
   output logic [WIDTH-1:0]       o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   assign do_pop  = i_pop && !empty_q;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign do_push = i_push && (!full_q || do_pop);

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // Head bypasses the memory when the new entry lands at the next read slot.
      if (count_d == '0) begin
         head_d = '0;
      end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
         head_d = i_wdata;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         full_q   <= (count_d == (AW+1)'(DEPTH));
         empty_q  <= (count_d == '0);
      end
   end

   assign o_head  = head_q;
   assign o_full  = full_q;
   assign o_empty = empty_q;
   assign o_count = count_q;

endmodule

// File: rtl/kbd_repeat_ctrl.sv
// Key-event sequencer: buffers presses, generates typematic repeat, presents one code at a time.
module kbd_repeat_ctrl
   import kbd_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH    = 8,
   parameter int unsigned REPEAT_DELAY  = KBD_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = KBD_REPEAT_PERIOD
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [6:0] i_ascii_code,
   input  logic       i_key_press,
   input  logic       i_key_release,
   input  logic       i_rd,
   output logic [6:0] o_data,
   output logic       o_ready,
   output logic       o_overflow
);

   localparam int unsigned CNT_W = $clog2(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] DELAY_TERM  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_TERM = CNT_W'(REPEAT_PERIOD - 1);

   rpt_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, term;
   logic             fire_q, fire_d;
   logic [6:0]       held_q, held_d;
   logic             ovf_q, ovf_d;

   logic                          push, pop;
   logic [6:0]                    push_data;
   logic                          fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;

   assign pop       = i_rd && !fifo_empty;
   assign push_data = i_key_press ? i_ascii_code : held_q;
   assign term      = (state_q == StDelay) ? DELAY_TERM : PERIOD_TERM;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire_d  = 1'b0;
      held_d  = held_q;
      ovf_d   = ovf_q;
      push    = 1'b0;

      if (pop) begin
         ovf_d = 1'b0;
      end

      if (i_key_press) begin
         // The key is down even when its code cannot be stored.
         push    = 1'b1;
         held_d  = i_ascii_code;
         state_d = StDelay;
         cnt_d   = '0;
         if (fifo_full && !pop) begin
            ovf_d = 1'b1;
         end
      end else if (i_key_release && (i_ascii_code == held_q)) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: cnt_d = '0;
            StDelay, StRepeat: begin
               if (fire_q) begin
                  // Only repeat into an empty buffer so a slow reader sees no backlog.
                  push    = (fifo_count == '0);
                  cnt_d   = '0;
                  state_d = StRepeat;
               end else if (cnt_q == term) begin
                  fire_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         fire_q  <= 1'b0;
         held_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fire_q  <= fire_d;
         held_q  <= held_d;
         ovf_q   <= ovf_d;
      end
   end

   sync_fifo #(
      .WIDTH (7),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push),
      .i_pop   (pop),
      .i_wdata (push_data),
      .o_head  (o_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_count)
   );

   assign o_ready    = !fifo_empty;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_kbd_repeat_ctrl.sv
// Directed bench for kbd_repeat_ctrl with short repeat timing and a 4-entry buffer.
module tb_kbd_repeat_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [6:0] i_ascii_code = '0;
   logic       i_key_press = 1'b0;
   logic       i_key_release = 1'b0;
   logic       i_rd = 1'b0;
   logic [6:0] o_data;
   logic       o_ready;
   logic       o_overflow;

   int n_assert = 0;
   int n_fail   = 0;

   kbd_repeat_ctrl #(
      .FIFO_DEPTH    (4),
      .REPEAT_DELAY  (20),
      .REPEAT_PERIOD (10)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_ascii_code  (i_ascii_code),
      .i_key_press   (i_key_press),
      .i_key_release (i_key_release),
      .i_rd          (i_rd),
      .o_data        (o_data),
      .o_ready       (o_ready),
      .o_overflow    (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic press(input logic [6:0] code);
      i_ascii_code = code;
      i_key_press  = 1'b1;
      tick();
      i_key_press  = 1'b0;
   endtask

   task automatic release_key(input logic [6:0] code);
      i_ascii_code  = code;
      i_key_release = 1'b1;
      tick();
      i_key_release = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic rdy, input logic [6:0] data,
                          input logic ovf);
      chk({tag, "_rdy"}, {7'd0, o_ready}, {7'd0, rdy});
      chk({tag, "_data"}, {1'b0, o_data}, {1'b0, data});
      chk({tag, "_ovf"}, {7'd0, o_overflow}, {7'd0, ovf});
   endtask

   initial begin
      logic exp;

      // Reset state
      repeat (3) tick();
      chk_out("rst_hold", 1'b0, 7'h00, 1'b0);
      i_rst = 1'b0;
      tick();
      chk_out("rst_done", 1'b0, 7'h00, 1'b0);

      // Hold 0x41 with reads every cycle: visible at +1, +22, +33, +44; release at +50
      i_rd = 1'b1;
      press(7'h41);
      for (int j = 1; j <= 60; j++) begin
         exp = (j == 1) || (j == 22) || (j == 33) || (j == 44);
         chk_out("hold41", exp, exp ? 7'h41 : 7'h00, 1'b0);
         if (j == 50) release_key(7'h41);
         else tick();
      end

      // Rollover: most recent press wins, stale release ignored
      press(7'h61);
      chk_out("roll61", 1'b1, 7'h61, 1'b0);
      repeat (4) tick();
      press(7'h62);
      chk_out("roll62", 1'b1, 7'h62, 1'b0);
      tick();
      tick();
      release_key(7'h61);
      for (int j = 4; j <= 21; j++) begin
         chk("roll_gap_rdy", {7'd0, o_ready}, 8'd0);
         tick();
      end
      chk_out("roll62_rep", 1'b1, 7'h62, 1'b0);
      repeat (3) tick();
      release_key(7'h62);
      for (int j = 26; j <= 45; j++) begin
         chk("roll_stop_rdy", {7'd0, o_ready}, 8'd0);
         tick();
      end

      // Five presses without reads: four stored, overflow set, drain in order
      i_rd = 1'b0;
      press(7'h31);
      press(7'h32);
      press(7'h33);
      press(7'h34);
      press(7'h35);
      chk_out("ovf_full", 1'b1, 7'h31, 1'b1);
      i_rd = 1'b1;
      tick();
      chk_out("ovf_rd1", 1'b1, 7'h32, 1'b0);
      tick();
      chk_out("ovf_rd2", 1'b1, 7'h33, 1'b0);
      tick();
      chk_out("ovf_rd3", 1'b1, 7'h34, 1'b0);
      tick();
      chk_out("ovf_empty", 1'b0, 7'h00, 1'b0);
      release_key(7'h35);
      for (int j = 0; j < 30; j++) begin
         chk("ovf_idle_rdy", {7'd0, o_ready}, 8'd0);
         tick();
      end

      // Held key with no reads: repeats never stack behind the unread entry
      i_rd = 1'b0;
      press(7'h51);
      for (int j = 1; j < 60; j++) begin
         chk_out("noread", 1'b1, 7'h51, 1'b0);
         tick();
      end
      chk_out("noread_end", 1'b1, 7'h51, 1'b0);
      i_rd = 1'b1;
      tick();
      i_rd = 1'b0;
      chk_out("noread_pop", 1'b0, 7'h00, 1'b0);
      release_key(7'h51);
      for (int j = 0; j < 10; j++) begin
         chk("noread_idle_rdy", {7'd0, o_ready}, 8'd0);
         tick();
      end

      // Full FIFO, press with simultaneous read: accepted, no overflow
      press(7'h11);
      press(7'h12);
      press(7'h13);
      press(7'h14);
      chk_out("pp_full", 1'b1, 7'h11, 1'b0);
      i_rd = 1'b1;
      press(7'h15);
      chk_out("pp_same", 1'b1, 7'h12, 1'b0);
      tick();
      chk_out("pp_d1", 1'b1, 7'h13, 1'b0);
      tick();
      chk_out("pp_d2", 1'b1, 7'h14, 1'b0);
      tick();
      chk_out("pp_d3", 1'b1, 7'h15, 1'b0);
      tick();
      chk_out("pp_empty", 1'b0, 7'h00, 1'b0);
      release_key(7'h15);
      i_rd = 1'b0;

      // Asynchronous reset mid-REPEAT with two entries queued
      press(7'h71);
      press(7'h72);
      chk_out("ar_q", 1'b1, 7'h71, 1'b0);
      repeat (25) tick();
      chk_out("ar_pre", 1'b1, 7'h71, 1'b0);
      #2;
      i_rst = 1'b1;
      #1;
      chk_out("ar_async", 1'b0, 7'h00, 1'b0);
      tick();
      tick();
      i_rst = 1'b0;
      for (int j = 0; j < 40; j++) begin
         chk("ar_norep_rdy", {7'd0, o_ready}, 8'd0);
         tick();
      end
      press(7'h73);
      chk_out("ar_new", 1'b1, 7'h73, 1'b0);
      release_key(7'h73);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
